apb_write_master: RTL

Upstream APB write master that feeds the APB write pipeline stage. It accepts 32-bit write words through a valid/ready request port and buffers them in a small FIFO. It then drives north-side APB write transfers (SETUP then ACCESS) back-to-back, with no PREADY, since the downstream stage always completes ACCESS in one cycle. A 16-bit counter reports completed transfers for end-of-test checking.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_write_master_if.sv | 25 ++
 rtl/apb_write_master_fifo.sv | 58 +++++
 rtl/apb_write_master.sv | 106 ++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB write-master types: FSM state encoding and data word type.
package apb_pkg;
    localparam int APB_DATA_WIDTH = 32;

    typedef logic [APB_DATA_WIDTH-1:0] apb_data_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;
endpackage

// File: rtl/apb_write_master_if.sv
// Request port plus north-side APB write outputs of apb_write_master.
interface apb_write_master_if #(
    parameter int CNT_WIDTH = 16
);
    import apb_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    apb_data_t            req_data;
    logic                 psel;
    logic                 penable;
    apb_data_t            pwdata;
    logic                 busy;
    logic [CNT_WIDTH-1:0] xfer_count;

    modport master (
        input  req_valid, req_data,
        output req_ready, psel, penable, pwdata, busy, xfer_count
    );

    modport slave (
        output req_valid, req_data,
        input  req_ready, psel, penable, pwdata, busy, xfer_count
    );
endinterface

// File: rtl/apb_write_master_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head, 0-cycle read latency.
// Push when full and pop when empty are ignored; async reset flushes it.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/apb_write_master.sv
// Buffers request words and issues back-to-back APB writes (SETUP, ACCESS); first SETUP one cycle after acceptance.
// req_ready drops when DEPTH words are pending, counting the word currently on the bus; no look-ahead on the pop.
module apb_write_master
    import apb_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    apb_write_master_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    apb_state_e           state;
    logic                 psel_q;
    logic                 penable_q;
    apb_data_t            pwdata_q;
    logic [CNT_WIDTH-1:0] count_q;

    apb_data_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic [AW:0] pending;
    logic        in_flight;
    logic        accept;
    logic        refill;
    logic        load;
    logic        bypass;

    // The word on the bus is moved out of the FIFO into pwdata when its SETUP
    // starts, so it still counts toward capacity until its ACCESS completes.
    assign in_flight = (state != IDLE);
    assign pending   = fifo_count + {{AW{1'b0}}, in_flight};

    assign bus.req_ready = (pending != (AW+1)'(DEPTH)) && !fifo_full && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // A word arriving on the last ACCESS edge goes straight into pwdata.
    assign refill = (state == ACCESS) && (!fifo_empty || accept);
    assign load   = ((state == IDLE) && !fifo_empty) || refill;
    assign bypass = (state == ACCESS) && fifo_empty && accept;

    sync_fifo #(
        .WIDTH (APB_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && !bypass),
        .pop   (load && !fifo_empty),
        .wdata (bus.req_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
            count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwdata_q  <= head;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    count_q   <= count_q + CNT_WIDTH'(1);
                    penable_q <= 1'b0;
                    if (refill) begin
                        state    <= SETUP;
                        pwdata_q <= fifo_empty ? bus.req_data : head;
                    end else begin
                        state  <= IDLE;
                        psel_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.xfer_count = count_q;
    assign bus.busy       = !fifo_empty || in_flight;
endmodule
